// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_dataflow.sv
// 1-bit full-adder cell, dataflow form.
module fa_dataflow (
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic ci
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full-adder cell, one bit per clock, LSB first.
// Optional macro SERIAL_ADD_SUB_EN adds a `sub` input for a - b.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] s_sh_q;
    logic [WIDTH-1:0] s_sh_d;
    logic [WIDTH-1:0] b_load_d;
    logic             carry_load_d;
    logic             carry_q;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             cell_s;
    logic             cell_co;

    fa_dataflow u_cell (
        .s  (cell_s),
        .co (cell_co),
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q)
    );

    assign s_sh_d = {cell_s, s_sh_q[WIDTH-1:1]};

    // Subtraction is a + ~b + 1: invert b at capture and force the initial carry.
`ifdef SERIAL_ADD_SUB_EN
    assign b_load_d     = sub ? ~b : b;
    assign carry_load_d = sub ? 1'b1 : ci;
`else
    assign b_load_d     = b;
    assign carry_load_d = ci;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b_load_d;
                        carry_q <= carry_load_d;
                        count_q <= '0;
                        s_sh_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    s_sh_q  <= s_sh_d;
                    carry_q <= cell_co;
                    count_q <= count_q + CNT_W'(1);
                    // Result registers take the final bit directly so s/co never show partial sums.
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        s_q     <= s_sh_d;
                        co_q    <= cell_co;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign co   = co_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8); sub tests need SERIAL_ADD_SUB_EN.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       busy;
    logic       done;
    logic [7:0] s;
    logic       co;
`ifdef SERIAL_ADD_SUB_EN
    logic       sub;
`endif

    int checks   = 0;
    int failures = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] exp_s;
        logic       exp_co;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives a start pulse at a negedge and follows the operation to its done pulse.
    task automatic run_op(input string name, input logic [7:0] va, input logic [7:0] vb,
                          input logic vci, input logic [7:0] es, input logic eco);
        int cnt;
        a     = va;
        b     = vb;
        ci    = vci;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, " busy_after_start"}, 32'(busy), 32'd1);
        cnt = 0;
        while (busy && cnt < 40) begin
            chk({name, " no_done_while_busy"}, 32'(done), 32'd0);
            cnt++;
            @(negedge clk);
        end
        chk({name, " busy_cycles"}, 32'(cnt), 32'd8);
        chk({name, " done"}, 32'(done), 32'd1);
        chk({name, " s"}, 32'(s), 32'(es));
        chk({name, " co"}, 32'(co), 32'(eco));
        @(negedge clk);
        chk({name, " done_one_cycle"}, 32'(done), 32'd0);
        chk({name, " idle_not_busy"}, 32'(busy), 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        int cnt;
        int ndone;
        int last_done;
        int cyc;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
        vecs[3] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[7] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        ci    = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset s", 32'(s), 32'd0);
        chk("reset co", 32'(co), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci,
                   vecs[i].exp_s, vecs[i].exp_co);
        end

        // Start re-pulsed with other operands while busy must be ignored.
        a = 8'hA5; b = 8'h5A; ci = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        cnt = 0;
        repeat (25) begin
            cnt++;
            if (cnt == 3 || cnt == 8) begin
                a = 8'h11; b = 8'h22; ci = 1'b0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                chk("ignore_start s", 32'(s), 32'h00);
                chk("ignore_start co", 32'(co), 32'd1);
            end
            @(negedge clk);
        end
        chk("ignore_start done_pulses", 32'(ndone), 32'd1);
        chk("ignore_start idle", 32'(busy), 32'd0);

        // Reset during the 4th RUN cycle aborts the operation.
        a = 8'h33; b = 8'h44; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort s", 32'(s), 32'h00);
        chk("abort co", 32'(co), 32'd0);
        ndone = 0;
        repeat (15) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        chk("abort no_activity", 32'(ndone), 32'd0);
        run_op("after_abort", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

        // Held start: done every WIDTH+2 cycles, s stable once valid.
        a = 8'h21; b = 8'h13; ci = 1'b0; start = 1'b1;
        ndone = 0;
        last_done = 0;
        for (cyc = 1; cyc <= 32; cyc++) begin
            @(negedge clk);
            if (done) begin
                if (ndone == 0) chk("held first_done_cycle", 32'(cyc), 32'd9);
                else chk("held done_spacing", 32'(cyc - last_done), 32'd10);
                ndone++;
                last_done = cyc;
            end
            if (ndone > 0) chk("held s_stable", 32'(s), 32'h34);
        end
        chk("held done_pulses", 32'(ndone), 32'd3);
        start = 1'b0;
        cnt = 0;
        while ((busy || done) && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("held drained", 32'(busy | done), 32'd0);
        @(negedge clk);

`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b1;
        run_op("sub 10-01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
        run_op("sub 01-02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
        sub = 1'b0;
        run_op("sub0 add", 8'h01, 8'h02, 1'b1, 8'h04, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
